// File: rtl/cdb_pkg.sv
// Shared types for the common-data-bus arbiter.
// Widths default to XLEN=32 / ROB_TAG_LEN=5 unless the build defines them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

package cdb_pkg;

    localparam int XLEN          = `XLEN;
    localparam int ROB_TAG_LEN   = `ROB_TAG_LEN;
    localparam int CDB_NUM_FU    = 4;
    localparam int CDB_BUF_DEPTH = 2;

    // One completed result as it travels from an FU to the CDB.
    typedef struct packed {
        logic [XLEN-1:0]        value;
        logic [ROB_TAG_LEN-1:0] tag;
        logic [ROB_TAG_LEN-1:0] insn_tag;
    } CDB_PACKET;

    typedef logic [$clog2(CDB_NUM_FU)-1:0] fu_idx_t;

    // Wraps an index that may have run at most one lap past n-1.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU result buffer: DEPTH entries of CDB_PACKET, FIFO order.
// Flush empties it in one cycle; pointers wrap naturally (DEPTH is 2^n).
module cdb_result_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic      clock,
    input  logic      reset,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  CDB_PACKET din,
    output CDB_PACKET head,
    output logic      empty,
    output logic      full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    CDB_PACKET     mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign head    = mem_q[rd_q];
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~full & ~flush;

    // Storage array: written only on an accepted push.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    // Pointer and occupancy tracking; flush clears everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers FU completions and broadcasts one per cycle on the CDB, round-robin.
// Optional macro CDB_BYPASS_EN lets a live result on an empty FU win directly.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU    = CDB_NUM_FU,
    parameter int BUF_DEPTH = CDB_BUF_DEPTH
)
(
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [NUM_FU-1:0]                   fu_done,
    input  logic [NUM_FU-1:0][XLEN-1:0]         fu_result,
    input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]  fu_result_tag,
    input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]  fu_insn_tag,
    output logic [NUM_FU-1:0]                   fu_stall,
    output logic                                cdb_valid,
    output logic [XLEN-1:0]                     cdb_value,
    output logic [ROB_TAG_LEN-1:0]              cdb_tag,
    output logic [ROB_TAG_LEN-1:0]              cdb_insn_tag
);

    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    idx_t        rr_q;
    idx_t        rr_d;
    idx_t        win;
    logic        any;
    logic        cdb_valid_q;
    CDB_PACKET   cdb_q;
    CDB_PACKET   win_pkt;
    CDB_PACKET   head_pkt [NUM_FU];
    logic [NUM_FU-1:0] empty;
    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] cand;
    logic [NUM_FU-1:0] win_oh;
    logic [NUM_FU-1:0] bypass_taken;

`ifdef CDB_BYPASS_EN
    CDB_PACKET   live_pkt [NUM_FU];
`endif

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        CDB_PACKET din;

        assign din.value    = fu_result[i];
        assign din.tag      = fu_result_tag[i];
        assign din.insn_tag = fu_insn_tag[i];

`ifdef CDB_BYPASS_EN
        assign live_pkt[i] = din;
`endif

        cdb_result_fifo #(
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (din),
            .head  (head_pkt[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    // Stall depends on registered occupancy only.
    assign fu_stall = full;

    // Candidate set: buffered heads, plus live inputs on empty FUs with bypass.
    always_comb begin
        cand = ~empty;
`ifdef CDB_BYPASS_EN
        cand = ~empty | (fu_done & empty & {NUM_FU{~flush}});
`endif
    end

    // Round-robin search from rr_q upward, wrapping to 0.
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            int idx;
            idx = rr_wrap(int'(rr_q) + k, NUM_FU);
            if (!any && cand[idx]) begin
                any = 1'b1;
                win = idx_t'(idx);
            end
        end
    end

    // Winner decode, pops, pushes and next round-robin pointer.
    always_comb begin
        win_oh       = any ? (NUM_FU'(1) << win) : '0;
        bypass_taken = '0;
`ifdef CDB_BYPASS_EN
        bypass_taken = win_oh & empty;
        win_pkt      = empty[win] ? live_pkt[win] : head_pkt[win];
`else
        win_pkt      = head_pkt[win];
`endif
        pop  = win_oh & ~empty;
        push = fu_done & ~full & ~bypass_taken & {NUM_FU{~flush}};
        rr_d = idx_t'(rr_wrap(int'(win) + 1, NUM_FU));
    end

    // CDB output registers and rotation pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
            rr_q        <= '0;
        end else if (flush) begin
            cdb_valid_q <= 1'b0;
            rr_q        <= '0;
        end else begin
            cdb_valid_q <= any;
            if (any) begin
                cdb_q <= win_pkt;
                rr_q  <= rr_d;
            end
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_value    = cdb_q.value;
    assign cdb_tag      = cdb_q.tag;
    assign cdb_insn_tag = cdb_q.insn_tag;

`ifndef SYNTHESIS
    a_done_on_stall: assert property (
        @(posedge clock) disable iff (reset)
        !(|(fu_done & fu_stall))
    );
`endif

endmodule
